// File: rtl/uart_gcd_engine.sv
// uart_gcd_engine: parses decimal operands from a UART byte stream, echoes
// accepted digits, computes the running GCD of NUM_OPS operands with a
// subtractive Euclid datapath and prints the result as "0x<hex>\r\n".
module uart_gcd_engine #(
  parameter int WIDTH   = 16,  // operand/result width, multiple of 4, 8..32
  parameter int NUM_OPS = 2,   // operands per GCD, 2..8
  parameter int ECHO    = 1    // 1: echo accepted digits on tx
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             busy,
  output logic [WIDTH-1:0] gcd_out,
  output logic             gcd_valid,
  output logic             ovf_err
);

  localparam int NIB    = WIDTH / 4;
  localparam int NBYTES = NIB + 4;            // "0x", nibbles, CR, LF
  localparam int IDXW   = $clog2(NBYTES);
  localparam int OPW    = $clog2(NUM_OPS + 1);

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_ESC = 8'h1B;

  typedef enum logic [1:0] {S_ENTRY, S_GCD, S_OUT, S_ERR} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, g_q, a_q, b_q, gcd_out_q;
  logic [OPW-1:0]   op_idx_q;
  logic [IDXW-1:0]  out_idx_q;
  logic             digit_seen_q, ovf_q;
  logic             tx_valid_q, gcd_valid_q, ovf_err_q;
  logic [7:0]       tx_data_q;

  logic             is_digit;
  logic [WIDTH+3:0] acc_d;
  logic             acc_ovf;
  logic [WIDTH-1:0] nib_src;
  logic [3:0]       nibble;
  int               out_pos;
  logic [7:0]       out_byte_d;
  logic             out_last_d;

  // Decimal accumulate at WIDTH+4 bits so acc*10+9 can never wrap.
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign acc_d    = ({4'h0, acc_q} << 3) + ({4'h0, acc_q} << 1)
                  + {{WIDTH{1'b0}}, rx_data[3:0]};
  assign acc_ovf  = (acc_d[WIDTH+3:WIDTH] != 4'h0);

  // Nibble for output position 2..NIB+1, MSB first.
  assign out_pos = int'(out_idx_q);
  assign nib_src = gcd_out_q >> (4 * (NIB + 1 - out_pos));
  assign nibble  = nib_src[3:0];

  // Select the byte to present next in S_OUT / S_ERR.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    out_byte_d = CH_LF;
    out_last_d = 1'b0;
    if (state_q == S_ERR) begin
      out_last_d = (out_pos == 2);
      case (out_pos)
        0:       out_byte_d = 8'h45;  // "E"
        1:       out_byte_d = CH_CR;
        default: out_byte_d = CH_LF;
      endcase
    end else begin
      out_last_d = (out_pos == NBYTES - 1);
      if (out_pos == 0)             out_byte_d = 8'h30;  // "0"
      else if (out_pos == 1)        out_byte_d = 8'h78;  // "x"
      else if (out_pos < NIB + 2)   out_byte_d = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                                                  : (8'h37 + {4'h0, nibble});
      else if (out_pos == NIB + 2)  out_byte_d = CH_CR;
      else                          out_byte_d = CH_LF;
    end
  end

  // Control FSM, datapath and registered outputs.
  // NOTE: all state, datapath included, is reset so the block restarts cleanly mid-computation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_ENTRY;
      acc_q        <= '0;
      g_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      gcd_out_q    <= '0;
      op_idx_q     <= '0;
      out_idx_q    <= '0;
      digit_seen_q <= 1'b0;
      ovf_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      gcd_valid_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      gcd_valid_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      case (state_q)
        S_ENTRY: begin
          if (tx_valid_q && tx_ready) tx_valid_q <= 1'b0;
          if (rx_valid) begin
            if (is_digit) begin
              // A full echo slot drops the digit entirely.
              if (!ovf_q && !tx_valid_q) begin
                if (acc_ovf) begin
                  ovf_q <= 1'b1;
                end else begin
                  acc_q        <= acc_d[WIDTH-1:0];
                  digit_seen_q <= 1'b1;
                  if (ECHO != 0) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= rx_data;
                  end
                end
              end
            end else if (rx_data == CH_CR) begin
              if (digit_seen_q && !tx_valid_q) begin
                acc_q        <= '0;
                digit_seen_q <= 1'b0;
                ovf_q        <= 1'b0;
                if (ovf_q) begin
                  ovf_err_q <= 1'b1;
                  op_idx_q  <= '0;
                  g_q       <= '0;
                  out_idx_q <= '0;
                  state_q   <= S_ERR;
                end else begin
                  op_idx_q <= op_idx_q + OPW'(1);
                  if (op_idx_q == '0) begin
                    g_q <= acc_q;
                  end else begin
                    a_q     <= g_q;
                    b_q     <= acc_q;
                    state_q <= S_GCD;
                  end
                end
              end
            end else if (rx_data == CH_ESC) begin
              acc_q        <= '0;
              digit_seen_q <= 1'b0;
              ovf_q        <= 1'b0;
              op_idx_q     <= '0;
              g_q          <= '0;
            end
          end
        end
        S_GCD: begin
          if (a_q < b_q) begin
            a_q <= b_q;
            b_q <= a_q;
          end else if (b_q != '0) begin
            a_q <= a_q - b_q;
          end else begin
            g_q <= a_q;
            if (op_idx_q == OPW'(NUM_OPS)) begin
              gcd_out_q   <= a_q;
              gcd_valid_q <= 1'b1;
              out_idx_q   <= '0;
              state_q     <= S_OUT;
            end else begin
              state_q <= S_ENTRY;
            end
          end
        end
        S_OUT, S_ERR: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= out_byte_d;
          end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
            if (out_last_d) begin
              op_idx_q <= '0;
              state_q  <= S_ENTRY;
            end else begin
              out_idx_q <= out_idx_q + IDXW'(1);
            end
          end
        end
        default: state_q <= S_ENTRY;
      endcase
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != S_ENTRY);
  assign gcd_out   = gcd_out_q;
  assign gcd_valid = gcd_valid_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_uart_gcd_engine.sv
// Scoreboard bench for uart_gcd_engine: two instances (16-bit/2 operands and
// 32-bit/3 operands) exercised one at a time through a shared stimulus path.
module tb_uart_gcd_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxv;
  logic [7:0]  rxd;
  logic        rdy;
  logic        sel;

  logic        tx_valid0, busy0, gcd_valid0, ovf_err0;
  logic [7:0]  tx_data0;
  logic [15:0] gcd_out0;
  logic        tx_valid1, busy1, gcd_valid1, ovf_err1;
  logic [7:0]  tx_data1;
  logic [31:0] gcd_out1;

  logic        m_tx_valid, m_busy, m_gcd_valid, m_ovf_err;
  logic [7:0]  m_tx_data;
  logic [31:0] m_gcd_out;

  always #5 clk = ~clk;

  uart_gcd_engine #(.WIDTH(16), .NUM_OPS(2), .ECHO(1)) dut0 (
    .clk(clk), .reset_n(rst_n), .rx_valid(rxv && !sel), .rx_data(rxd),
    .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(rdy), .busy(busy0),
    .gcd_out(gcd_out0), .gcd_valid(gcd_valid0), .ovf_err(ovf_err0));

  uart_gcd_engine #(.WIDTH(32), .NUM_OPS(3), .ECHO(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .rx_valid(rxv && sel), .rx_data(rxd),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(rdy), .busy(busy1),
    .gcd_out(gcd_out1), .gcd_valid(gcd_valid1), .ovf_err(ovf_err1));

  assign m_tx_valid  = sel ? tx_valid1  : tx_valid0;
  assign m_tx_data   = sel ? tx_data1   : tx_data0;
  assign m_busy      = sel ? busy1      : busy0;
  assign m_gcd_valid = sel ? gcd_valid1 : gcd_valid0;
  assign m_ovf_err   = sel ? ovf_err1   : ovf_err0;
  assign m_gcd_out   = sel ? gcd_out1   : {16'h0000, gcd_out0};

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and pulse counters.
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_gcd[$];
  int gcd_exp_cnt = 0, gcd_seen = 0;
  int ovf_exp_cnt = 0, ovf_seen = 0;

  // Reference model state.
  int              mw, mn;
  longint unsigned m_acc;
  bit              m_seen, m_ovf;
  int              m_ops;
  longint unsigned m_g;

  bit rand_ready = 1'b0;
  bit hold_ready = 1'b0;

  string cr  = "\015";
  string esc = "\033";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: actual 0x%0h required nothing", name, act);
  endtask

  function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic void push_hex(input longint unsigned v);
    int nib;
    exp_tx.push_back(8'h30);
    exp_tx.push_back(8'h78);
    for (int k = mw / 4 - 1; k >= 0; k--) begin
      nib = int'((v >> (4 * k)) & 64'hF);
      exp_tx.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
    end
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
  endfunction

  function automatic void model_clear();
    m_acc = 0; m_seen = 0; m_ovf = 0; m_ops = 0; m_g = 0;
  endfunction

  // Behavioural model of one byte arriving while the engine is idle.
  function automatic void model_byte(input logic [7:0] c);
    longint unsigned v;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (!m_ovf) begin
        v = m_acc * 10 + longint'(c - 8'h30);
        if (v > (64'd1 << mw) - 1) m_ovf = 1;
        else begin
          m_acc = v;
          m_seen = 1;
          exp_tx.push_back(c);
        end
      end
    end else if (c == 8'h0D) begin
      if (m_seen) begin
        if (m_ovf) begin
          ovf_exp_cnt++;
          exp_tx.push_back(8'h45);
          exp_tx.push_back(8'h0D);
          exp_tx.push_back(8'h0A);
          model_clear();
        end else begin
          m_g = (m_ops == 0) ? m_acc : ref_gcd(m_g, m_acc);
          m_ops++;
          m_acc = 0; m_seen = 0;
          if (m_ops == mn) begin
            exp_gcd.push_back(32'(m_g));
            gcd_exp_cnt++;
            push_hex(m_g);
            m_ops = 0;
          end
        end
      end
    end else if (c == 8'h1B) begin
      model_clear();
    end
  endfunction

  // tx_ready driver: steady, random, or held low.
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready)      rdy = 1'b0;
      else if (rand_ready) rdy = 1'($urandom_range(0, 1));
      else                 rdy = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    logic       stalled;
    logic [7:0] held;
    stalled = 1'b0;
    held    = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("tx_hold", {23'h0, m_tx_valid, m_tx_data}, {23'h0, 1'b1, held});
        if (m_tx_valid && rdy) begin
          if (exp_tx.size() == 0) flag_unexpected("tx_unexpected", {24'h0, m_tx_data});
          else check("tx_byte", {24'h0, m_tx_data}, {24'h0, exp_tx.pop_front()});
        end
        stalled = m_tx_valid && !rdy;
        held    = m_tx_data;
        if (m_gcd_valid) begin
          gcd_seen++;
          if (exp_gcd.size() == 0) flag_unexpected("gcd_unexpected", m_gcd_out);
          else check("gcd_out", m_gcd_out, exp_gcd.pop_front());
        end
        if (m_ovf_err) ovf_seen++;
      end
    end
  end

  task automatic send_raw(input logic [7:0] c);
    @(posedge clk);
    #1;
    rxv = 1'b1;
    rxd = c;
    @(posedge clk);
    #1;
    rxv = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    repeat (2) @(posedge clk);
    for (int n = 0; n < 20000 && !done; n++) begin
      @(negedge clk);
      if (!m_busy && !m_tx_valid) done = 1'b1;
    end
    check("idle_reached", {30'h0, m_busy, m_tx_valid}, 32'h0);
  endtask

  task automatic send(input logic [7:0] c);
    model_byte(c);
    send_raw(c);
    wait_idle();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic select_dut(input logic which, input int w, input int n);
    sel = which;
    mw  = w;
    mn  = n;
    model_clear();
    repeat (2) @(posedge clk);
  endtask

  task automatic random_groups(input int groups, input bit allow_ovf);
    int v;
    for (int t = 0; t < groups; t++) begin
      rand_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) send(8'h1B);
      if (allow_ovf && $urandom_range(0, 7) == 0) v = int'($urandom_range(65536, 99999));
      else v = int'($urandom_range(0, 999));
      send_str({$sformatf("%0d", v), cr});
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    int base;
    bit seen_busy;
    rst_n = 1'b0;
    rxv   = 1'b0;
    rxd   = 8'h00;
    sel   = 1'b0;
    mw    = 16;
    mn    = 2;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, tx_valid0}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data0}, 32'h0);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_gcd_out", {16'h0, gcd_out0}, 32'h0);
    check("rst_flags", {30'h0, gcd_valid0, ovf_err0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    select_dut(1'b0, 16, 2);

    // Basic pair; a digit sent while busy must be dropped.
    send_str({"48", cr, "18"});
    model_byte(8'h0D);
    send_raw(8'h0D);
    seen_busy = 1'b0;
    for (int n = 0; n < 50 && !seen_busy; n++) begin
      @(negedge clk);
      if (m_busy) seen_busy = 1'b1;
    end
    check("busy_after_commit", {31'h0, m_busy}, 32'h1);
    send_raw(8'h39);
    wait_idle();
    check("gcd_out_holds", m_gcd_out, 32'h6);

    // Overflow then a normal pair.
    send_str({"65536", cr});
    check("ovf_pulses", ovf_seen, ovf_exp_cnt);
    send_str({"7", cr, "14", cr});

    // Zero cases and a bare CR.
    send_str({cr, "0", cr, "35", cr, "0", cr, "0", cr});

    // Random backpressure.
    rand_ready = 1'b1;
    send_str({"48", cr, "18", cr});
    rand_ready = 1'b0;

    // Echo slot held full: the next digit and CR are dropped.
    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_byte(8'h34);
    send_raw(8'h34);
    send_raw(8'h38);
    send_raw(8'h0D);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("echo_held", {23'h0, m_tx_valid, m_tx_data}, {23'h0, 1'b1, 8'h34});
    hold_ready = 1'b0;
    wait_idle();
    send_str({cr, "6", cr});

    // ESC discards the partial operand.
    send_str({"12", esc, "18", cr, "24", cr});

    random_groups(14, 1'b1);

    // Reset in the middle of a long subtraction run.
    send_str({"65535", cr, "1"});
    send_raw(8'h0D);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("busy_mid_gcd", {31'h0, m_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_valid", {31'h0, m_tx_valid}, 32'h0);
    check("rst_mid_busy", {31'h0, m_busy}, 32'h0);
    check("rst_mid_gcd_out", m_gcd_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    send_str({"9", cr, "6", cr});
    check("gcd_pulses_w16", gcd_seen, gcd_exp_cnt);

    // Wide instance, three operands.
    select_dut(1'b1, 32, 3);
    base = gcd_seen;
    send_str({"12", cr, "18", cr, "27", cr});
    check("gcd_single_pulse", gcd_seen - base, 32'h1);
    random_groups(9, 1'b0);

    repeat (5) @(posedge clk);
    check("tx_leftover", exp_tx.size(), 32'h0);
    check("gcd_leftover", exp_gcd.size(), 32'h0);
    check("gcd_pulses_total", gcd_seen, gcd_exp_cnt);
    check("ovf_pulses_total", ovf_seen, ovf_exp_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
